disaggregator: RTL

Parallel-to-serial word splitter: accepts one packed vector of `N_WORDS` words of `WIDTH` bits and emits the words one at a time, lowest word first, over a valid/ready stream. It is the write-side inverse of the `aggregator`. It feeds per-word consumers such as `single_port_sram` write ports and pipeline stages from wide buffers. An optional initiation interval `II` enforces a minimum spacing between emitted words, matching the `count_every_ii_*` schedules.

---
 rtl/disaggregator.sv | 117 +++++++++++
 1 files changed

// File: rtl/disaggregator.sv
// disaggregator: splits one packed vector into WIDTH-bit words,
// emitted lowest first over valid/ready with optional II spacing.
module disaggregator #(
  parameter int WIDTH   = 8,
  parameter int N_WORDS = 4,
  parameter int II      = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_WORDS*WIDTH-1:0]   in,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       busy
);

  localparam int IW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_WORDS - 1);
  localparam logic [31:0] GAP0 = 32'(II - 1);

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    WAIT
  } state_t;

  state_t state;
  state_t state_nx;

  logic [N_WORDS-1:0][WIDTH-1:0] vec;
  logic [IW-1:0] idx;
  logic [31:0]   gap;
  logic          armed;
  logic          at_last;
  logic          emit;
  logic          load;

  assign at_last = (state == EMIT) && (idx == LAST);
  assign emit    = (state == EMIT) && out_ready;
  assign load    = in_valid && in_ready;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (load) state_nx = EMIT;
      end
      EMIT: begin
        if (emit) begin
          if (at_last && !load) state_nx = IDLE;
          else if (II > 1)      state_nx = WAIT;
          else                  state_nx = EMIT;
        end
      end
      WAIT: begin
        if (gap == 32'd1) state_nx = EMIT;
      end
      default: state_nx = IDLE;
    endcase
  end

  // armed keeps in_ready low until the first edge after reset release
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out       = '0;
    out_last  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = armed;
      end
      EMIT: begin
        out_valid = 1'b1;
        out       = vec[idx];
        out_last  = at_last;
        in_ready  = armed && at_last && out_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vec   <= '0;
      idx   <= '0;
      gap   <= '0;
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (load) begin
        vec <= in;
        idx <= '0;
        gap <= (state == EMIT) ? GAP0 : '0;
      end else if (emit && !at_last) begin
        idx <= idx + 1'b1;
        gap <= GAP0;
      end else if (emit) begin
        idx <= '0;
      end else if (state == WAIT) begin
        gap <= gap - 32'd1;
      end
    end
  end

endmodule
